stu_packet_tx: RTL
==================

# stu_packet_tx

Stack-side upstream packet transmitter: accepts PE result words over a simple valid/ready stream, buffers them, and drives the manager's upstream stack bus (stu__mgr__*) with correctly delineated packets. Each packet's tag is carried on the OOB data lane on every beat. It is the transmitting end of the interface whose receiver is the manager's stu_cntl.

## Interface
- DATA_W, 64, upstream data lane width (STACK_UP_INTF_DATA)
- TAG_W, 8, packet tag width (STACK_DOWN_OOB_INTF_TAG)
- TYPE_W, 2, upstream type width (STACK_UP_INTF_TYPE)
- OOB_W, 8, OOB data lane width; must satisfy OOB_W >= TAG_W
- FIFO_DEPTH, 4, input buffer entries; power of two
- MAX_PKT_WORDS, 32, maximum beats per packet
- clk  in  1  system clock
- reset_poweron  in  1  synchronous, active-high reset
- pe__stu__valid  in  1  input word valid
- stu__pe__ready  out  1  input ready; equals !fifo_full
- pe__stu__data  in  DATA_W  result word
- pe__stu__tag  in  TAG_W  packet tag; sampled on the packet's first word
- pe__stu__type  in  TYPE_W  control/data, vector/scalar
- pe__stu__last  in  1  marks the last word of a packet
- stu__mgr__valid  out  1  upstream beat valid
- stu__mgr__cntl  out  2  {EOM,SOM}: 01 SOM, 00 MOM, 10 EOM, 11 SOM_EOM
- mgr__stu__ready  in  1  manager ready
- stu__mgr__type  out  TYPE_W  beat type
- stu__mgr__data  out  DATA_W  beat data
- stu__mgr__oob_data  out  OOB_W  packet tag, zero-extended
- stu__sys__len_err  out  1  sticky; set when a packet is truncated
- stu__sys__pkt_count  out  16  packets sent (present only with STU_PACKET_TX_STATS_EN)

## Operation
- Input transfer occurs when pe__stu__valid & stu__pe__ready. The word, tag, type and last are pushed into the FIFO.
- Output stage is a single register slot. It loads from the FIFO head when the slot is empty, or when the slot is being accepted this cycle (valid & ready).
- FSM has two states, IDLE and IN_PKT.
  - IDLE: the next loaded word gets SOM. Its tag is latched into pkt_tag and the state moves to IN_PKT, unless the word is also last, in which case cntl=SOM_EOM and the state stays IDLE.
  - IN_PKT: loaded words get MOM, or EOM if last. After EOM the state returns to IDLE.
- The FSM advances on output-slot load, not on manager acceptance.
- stu__mgr__oob_data is driven from pkt_tag for every beat of the packet. Tag changes on later input words of the same packet are ignored.
- A beat counter increments per loaded word in IN_PKT.
  - When the counter reaches MAX_PKT_WORDS-1 and the word is not last, that word is forced to EOM, len_err is set, and the state returns to IDLE.
  - The next word then starts a new packet with a freshly latched tag.
- Output stability: once stu__mgr__valid is high, data, cntl, type and oob_data hold until accepted.

## Timing
- Reset values: stu__mgr__valid 0, stu__mgr__cntl 00, data/type/oob 0, stu__pe__ready 1, len_err 0, pkt_count 0. The FIFO is empty and the FSM is in IDLE.
- Latency: a word accepted at cycle N into an empty block appears with stu__mgr__valid=1 at cycle N+1 (the FIFO is bypassed into the slot).
- Throughput: 1 beat/cycle while mgr__stu__ready=1.
- FIFO full: stu__pe__ready=0. A push is never accepted when full, even if a pop occurs in the same cycle (ready is not combinationally dependent on mgr__stu__ready).
- FIFO empty with the slot accepted: stu__mgr__valid drops the next cycle.
- Simultaneous push and pop when not full: the occupancy count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-packet: the FIFO is flushed, the slot is invalidated, and the FSM goes to IDLE. The partial packet is abandoned with no EOM sent.

## Configuration
- STU_PACKET_TX_STATS_EN defined:
  - stu__sys__pkt_count exists.
  - It increments by 1 on each accepted beat whose cntl is EOM or SOM_EOM, and wraps from 0xFFFF to 0.
- STU_PACKET_TX_STATS_EN undefined: the port and counter are absent and all other behaviour is identical.

## Test plan
- Single word, tag 0x5A, last=1, ready=1 → one beat at N+1 with cntl=11 and oob=0x5A; pkt_count becomes 1.
- 4-word packet with tag 0x11, then 2-word packet with tag 0x22, continuous → cntl sequence 01,00,00,10,01,10; oob 0x11×4 then 0x22×2; no bubbles.
- Hold mgr__stu__ready=0 while pushing 6 words → stu__pe__ready falls after FIFO_DEPTH+1 words accepted; output held stable; ready released → all 6 delivered in order.
- 40 words with no last, MAX_PKT_WORDS=32 → beat 32 carries cntl=10; len_err=1; beat 33 carries cntl=01 with a newly latched tag.
- Tag input changed to 0xFF mid-packet → oob stays at the first-word tag until EOM.
- reset_poweron asserted for 1 cycle during a 3rd beat with the FIFO holding 3 words → next cycle valid=0 and ready=1; next input starts with SOM.

Source files
------------

// File: rtl/stu_packet_tx.sv
// Upstream stack-bus packet transmitter: PE result stream -> FIFO -> single output slot with SOM/MOM/EOM framing.
// Optional STU_PACKET_TX_STATS_EN adds the stu__sys__pkt_count packet counter.
module stu_packet_tx #(
   parameter int DATA_W        = 64,
   parameter int TAG_W         = 8,
   parameter int TYPE_W        = 2,
   parameter int OOB_W         = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_PKT_WORDS = 32
) (
   input  logic              clk,
   input  logic              reset_poweron,
   input  logic              pe__stu__valid,
   output logic              stu__pe__ready,
   input  logic [DATA_W-1:0] pe__stu__data,
   input  logic [TAG_W-1:0]  pe__stu__tag,
   input  logic [TYPE_W-1:0] pe__stu__type,
   input  logic              pe__stu__last,
   output logic              stu__mgr__valid,
   output logic [1:0]        stu__mgr__cntl,
   input  logic              mgr__stu__ready,
   output logic [TYPE_W-1:0] stu__mgr__type,
   output logic [DATA_W-1:0] stu__mgr__data,
   output logic [OOB_W-1:0]  stu__mgr__oob_data,
   output logic              stu__sys__len_err
`ifdef STU_PACKET_TX_STATS_EN
   ,
   output logic [15:0]       stu__sys__pkt_count
`endif
);
   // state   | meaning
   // IDLE    | next loaded word opens a packet (SOM, tag latched)
   // IN_PKT  | packet open; loaded words get MOM, or EOM on last/overlength

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(MAX_PKT_WORDS + 1);

   typedef enum logic {IDLE, IN_PKT} state_t;

   typedef struct packed {
      logic              last;
      logic [TYPE_W-1:0] typ;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } word_t;

   word_t          mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           fifo_empty, push_ok, slot_free, load, bypass, fifo_push, fifo_pop;
   word_t          in_word, ld_word;

   state_t         state, next_state;
   logic [1:0]     ld_cntl;
   logic           force_eom;
   logic [BW-1:0]  beat_cnt;
   logic [TAG_W-1:0] pkt_tag;

   assign in_word        = '{last: pe__stu__last, typ: pe__stu__type, tag: pe__stu__tag, data: pe__stu__data};
   assign stu__pe__ready = (count != CW'(FIFO_DEPTH));
   assign fifo_empty     = (count == '0);
   assign push_ok        = pe__stu__valid & stu__pe__ready;
   assign slot_free      = ~stu__mgr__valid | mgr__stu__ready;
   assign load           = slot_free & (~fifo_empty | push_ok);
   // An empty FIFO lets the incoming word go straight to the slot for one-cycle latency.
   assign bypass         = slot_free & fifo_empty & push_ok;
   assign fifo_push      = push_ok & ~bypass;
   assign fifo_pop       = slot_free & ~fifo_empty;
   assign ld_word        = fifo_empty ? in_word : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (fifo_push) mem[wr_ptr] <= in_word;
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
         if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) state <= IDLE;
      else               state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (load) next_state = ld_cntl[1] ? IDLE : IN_PKT;
   end

   always_comb begin
      force_eom = 1'b0;
      ld_cntl   = 2'b00;
      case (state)
         IDLE:    ld_cntl = {ld_word.last, 1'b1};
         IN_PKT: begin
            force_eom = ~ld_word.last & (beat_cnt == BW'(MAX_PKT_WORDS - 1));
            ld_cntl   = {ld_word.last | force_eom, 1'b0};
         end
         default: ld_cntl = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         stu__mgr__valid    <= 1'b0;
         stu__mgr__cntl     <= 2'b00;
         stu__mgr__type     <= '0;
         stu__mgr__data     <= '0;
         stu__mgr__oob_data <= '0;
         stu__sys__len_err  <= 1'b0;
         pkt_tag            <= '0;
         beat_cnt           <= '0;
      end else if (load) begin
         stu__mgr__valid <= 1'b1;
         stu__mgr__cntl  <= ld_cntl;
         stu__mgr__type  <= ld_word.typ;
         stu__mgr__data  <= ld_word.data;
         if (state == IDLE) begin
            pkt_tag            <= ld_word.tag;
            stu__mgr__oob_data <= OOB_W'(ld_word.tag);
            beat_cnt           <= BW'(1);
         end else begin
            stu__mgr__oob_data <= OOB_W'(pkt_tag);
            beat_cnt           <= beat_cnt + BW'(1);
         end
         if (force_eom) stu__sys__len_err <= 1'b1;
      end else if (mgr__stu__ready) begin
         stu__mgr__valid <= 1'b0;
      end
   end

`ifdef STU_PACKET_TX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset_poweron)
         stu__sys__pkt_count <= '0;
      else if (stu__mgr__valid & mgr__stu__ready & stu__mgr__cntl[1])
         stu__sys__pkt_count <= stu__sys__pkt_count + 16'd1;
   end
`endif

endmodule
